// File: rtl/execute_regread.sv
// execute_regread: register-read / issue stage feeding the execute units.
//
// Owns the integer register file and accepts one decoded instruction at a time.
// Operands are captured on accept (write-first against a same-cycle writeback),
// presented for exactly one cycle with read_valid_o, and the instruction fields
// stay on exec_*_o until an execute unit finishes or nobody claims the op.
//
// Ports
//   clk_i, reset_i             clock, synchronous active-high reset
//   flush_i                    abandon the in-flight instruction (highest priority)
//   decode_valid_i/ready_o     instruction handshake; ready only in idle without flush
//   decode_{opcode,funct3,funct7,imm,rs1,rs2,rd}_i   decoded instruction
//   wb_valid_i, wb_rd_i, wb_val_i                    register write port (x0 ignored)
//   exec_processing_i, exec_done_i                   OR of execute-unit status
//   read_valid_o, read_rs{1,2}_val_o                 operand pulse and values
//   exec_{opcode,funct3,funct7,imm,rd}_o             held instruction fields
//   exec_illegal_o             pulse: no execute unit claimed the instruction
module execute_regread #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned NUM_REGS    = 32,
  parameter bit          RESET_CLEAR = 1'b1,
  localparam int unsigned AW         = $clog2(NUM_REGS)
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            flush_i,
  input  logic            decode_valid_i,
  output logic            decode_ready_o,
  input  logic [6:0]      decode_opcode_i,
  input  logic [2:0]      decode_funct3_i,
  input  logic [6:0]      decode_funct7_i,
  input  logic [XLEN-1:0] decode_imm_i,
  input  logic [AW-1:0]   decode_rs1_i,
  input  logic [AW-1:0]   decode_rs2_i,
  input  logic [AW-1:0]   decode_rd_i,
  input  logic            wb_valid_i,
  input  logic [AW-1:0]   wb_rd_i,
  input  logic [XLEN-1:0] wb_val_i,
  input  logic            exec_processing_i,
  input  logic            exec_done_i,
  output logic            read_valid_o,
  output logic [XLEN-1:0] read_rs1_val_o,
  output logic [XLEN-1:0] read_rs2_val_o,
  output logic [6:0]      exec_opcode_o,
  output logic [2:0]      exec_funct3_o,
  output logic [6:0]      exec_funct7_o,
  output logic [XLEN-1:0] exec_imm_o,
  output logic [AW-1:0]   exec_rd_o,
  output logic            exec_illegal_o
);

  typedef enum logic [1:0] {StIdle, StRead, StExec} state_e;

  state_e          state_q, state_d;
  logic            accept;
  logic            wb_en;

  logic [XLEN-1:0] regs_q [NUM_REGS];

  logic [XLEN-1:0] op1_q, op1_d, op2_q, op2_d;
  logic [AW-1:0]   rs1_q, rs1_d, rs2_q, rs2_d;
  logic [6:0]      opcode_q, opcode_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [6:0]      funct7_q, funct7_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [AW-1:0]   rd_q, rd_d;

  // x0 is never written, so excluding it here also keeps it out of every bypass.
  assign wb_en = wb_valid_i && (wb_rd_i != '0);

  // Register file; with RESET_CLEAR=0 storage keeps its contents across reset.
  always_ff @(posedge clk_i) begin
    if (reset_i && RESET_CLEAR) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_en) begin
      regs_q[wb_rd_i] <= wb_val_i;
    end
  end

  // FSM next state and handshake/status outputs.
  always_comb begin
    state_d        = state_q;
    accept         = 1'b0;
    decode_ready_o = 1'b0;
    read_valid_o   = 1'b0;
    exec_illegal_o = 1'b0;
    if (flush_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          decode_ready_o = 1'b1;
          if (decode_valid_i) begin
            accept  = 1'b1;
            state_d = StRead;
          end
        end
        StRead: begin
          read_valid_o = 1'b1;
          if (exec_done_i) begin
            state_d = StIdle;
          end else if (exec_processing_i) begin
            state_d = StExec;
          end else begin
            exec_illegal_o = 1'b1;
            state_d        = StIdle;
          end
        end
        StExec: begin
          if (exec_done_i) begin
            state_d = StIdle;
          end else if (!exec_processing_i) begin
            exec_illegal_o = 1'b1;
            state_d        = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Capture on accept; write-first so a same-cycle writeback is not lost.
  always_comb begin
    op1_d    = op1_q;
    op2_d    = op2_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    opcode_d = opcode_q;
    funct3_d = funct3_q;
    funct7_d = funct7_q;
    imm_d    = imm_q;
    rd_d     = rd_q;
    if (accept) begin
      rs1_d    = decode_rs1_i;
      rs2_d    = decode_rs2_i;
      opcode_d = decode_opcode_i;
      funct3_d = decode_funct3_i;
      funct7_d = decode_funct7_i;
      imm_d    = decode_imm_i;
      rd_d     = decode_rd_i;
      if (decode_rs1_i == '0) begin
        op1_d = '0;
      end else if (wb_en && (wb_rd_i == decode_rs1_i)) begin
        op1_d = wb_val_i;
      end else begin
        op1_d = regs_q[decode_rs1_i];
      end
      if (decode_rs2_i == '0) begin
        op2_d = '0;
      end else if (wb_en && (wb_rd_i == decode_rs2_i)) begin
        op2_d = wb_val_i;
      end else begin
        op2_d = regs_q[decode_rs2_i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      op1_q    <= '0;
      op2_q    <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      opcode_q <= '0;
      funct3_q <= '0;
      funct7_q <= '0;
      imm_q    <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      opcode_q <= opcode_d;
      funct3_q <= funct3_d;
      funct7_q <= funct7_d;
      imm_q    <= imm_d;
      rd_q     <= rd_d;
    end
  end

  // A writeback landing in the operand cycle overrides the captured value.
  // wb_en already excludes x0, and a captured x0 operand is zero.
  always_comb begin
    read_rs1_val_o = (wb_en && (wb_rd_i == rs1_q)) ? wb_val_i : op1_q;
    read_rs2_val_o = (wb_en && (wb_rd_i == rs2_q)) ? wb_val_i : op2_q;
  end

  assign exec_opcode_o = opcode_q;
  assign exec_funct3_o = funct3_q;
  assign exec_funct7_o = funct7_q;
  assign exec_imm_o    = imm_q;
  assign exec_rd_o     = rd_q;

endmodule

// File: tb/tb_execute_regread.sv
// Bench for execute_regread: table-driven operand vectors, hand sequences for the
// multi-cycle cases, then randomized traffic against a transaction-level model.
module tb_execute_regread;

  logic        clk = 1'b0;
  logic        reset, flush, decode_valid, decode_ready;
  logic [6:0]  decode_opcode, decode_funct7;
  logic [2:0]  decode_funct3;
  logic [31:0] decode_imm;
  logic [4:0]  decode_rs1, decode_rs2, decode_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_val;
  logic        exec_processing, exec_done;
  logic        read_valid, exec_illegal;
  logic [31:0] read_rs1_val, read_rs2_val, exec_imm;
  logic [6:0]  exec_opcode, exec_funct7;
  logic [2:0]  exec_funct3;
  logic [4:0]  exec_rd;

  execute_regread dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .flush_i          (flush),
    .decode_valid_i   (decode_valid),
    .decode_ready_o   (decode_ready),
    .decode_opcode_i  (decode_opcode),
    .decode_funct3_i  (decode_funct3),
    .decode_funct7_i  (decode_funct7),
    .decode_imm_i     (decode_imm),
    .decode_rs1_i     (decode_rs1),
    .decode_rs2_i     (decode_rs2),
    .decode_rd_i      (decode_rd),
    .wb_valid_i       (wb_valid),
    .wb_rd_i          (wb_rd),
    .wb_val_i         (wb_val),
    .exec_processing_i(exec_processing),
    .exec_done_i      (exec_done),
    .read_valid_o     (read_valid),
    .read_rs1_val_o   (read_rs1_val),
    .read_rs2_val_o   (read_rs2_val),
    .exec_opcode_o    (exec_opcode),
    .exec_funct3_o    (exec_funct3),
    .exec_funct7_o    (exec_funct7),
    .exec_imm_o       (exec_imm),
    .exec_rd_o        (exec_rd),
    .exec_illegal_o   (exec_illegal)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: architectural registers plus the one instruction in flight.
  logic [31:0] m_regs [32];
  bit          m_busy, m_fresh;
  logic [6:0]  m_opc, m_f7;
  logic [2:0]  m_f3;
  logic [31:0] m_imm;
  logic [4:0]  m_rd, m_rs1, m_rs2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Architectural value of a register as seen this cycle (write-first).
  function automatic logic [31:0] arch_val(input logic [4:0] r);
    if (r == 5'd0) return 32'h0;
    if (wb_valid && wb_rd == r) return wb_val;
    return m_regs[r];
  endfunction

  task automatic check_model();
    bit e_rv;
    e_rv = m_busy && m_fresh && !flush;
    chk("m.decode_ready", {31'b0, decode_ready}, {31'b0, !m_busy && !flush});
    chk("m.read_valid", {31'b0, read_valid}, {31'b0, e_rv});
    chk("m.exec_illegal", {31'b0, exec_illegal},
        {31'b0, m_busy && !flush && !exec_done && !exec_processing});
    chk("m.exec_opcode", {25'b0, exec_opcode}, {25'b0, m_opc});
    chk("m.exec_funct3", {29'b0, exec_funct3}, {29'b0, m_f3});
    chk("m.exec_funct7", {25'b0, exec_funct7}, {25'b0, m_f7});
    chk("m.exec_imm", exec_imm, m_imm);
    chk("m.exec_rd", {27'b0, exec_rd}, {27'b0, m_rd});
    if (e_rv) begin
      chk("m.rs1_val", read_rs1_val, arch_val(m_rs1));
      chk("m.rs2_val", read_rs2_val, arch_val(m_rs2));
    end
  endtask

  task automatic m_reset();
    m_busy = 0; m_fresh = 0;
    m_opc = '0; m_f3 = '0; m_f7 = '0; m_imm = '0; m_rd = '0; m_rs1 = '0; m_rs2 = '0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
  endtask

  task automatic m_update();
    if (reset) begin
      m_reset();
    end else begin
      if (flush) begin
        m_busy = 0;
      end else if (!m_busy) begin
        if (decode_valid) begin
          m_busy = 1; m_fresh = 1;
          m_opc = decode_opcode; m_f3 = decode_funct3; m_f7 = decode_funct7;
          m_imm = decode_imm; m_rd = decode_rd; m_rs1 = decode_rs1; m_rs2 = decode_rs2;
        end
      end else if (exec_done || !exec_processing) begin
        m_busy = 0;
      end else begin
        m_fresh = 0;
      end
      if (wb_valid && wb_rd != 5'd0) m_regs[wb_rd] = wb_val;
    end
  endtask

  // Called with inputs already applied just after a falling edge.
  task automatic step();
    #1;
    check_model();
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  task automatic idle_in();
    reset = 0; flush = 0; decode_valid = 0; wb_valid = 0;
    exec_processing = 0; exec_done = 0;
  endtask

  task automatic offer(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] imm, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2);
    decode_valid = 1; decode_opcode = opc; decode_funct3 = f3; decode_funct7 = f7;
    decode_imm = imm; decode_rd = rd; decode_rs1 = rs1; decode_rs2 = rs2;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] v);
    wb_valid = 1; wb_rd = r; wb_val = v;
  endtask

  typedef struct {
    logic [4:0]  wr;
    logic [31:0] wval;
    logic [4:0]  rs1, rs2;
    logic [31:0] e1, e2;
  } tv_t;

  tv_t tv [6];

  initial begin
    tv[0] = '{5'd3,  32'hDEADBEEF, 5'd3,  5'd0,  32'hDEADBEEF, 32'h0};
    tv[1] = '{5'd4,  32'h00000001, 5'd3,  5'd4,  32'hDEADBEEF, 32'h1};
    tv[2] = '{5'd0,  32'hFFFFFFFF, 5'd0,  5'd3,  32'h0,        32'hDEADBEEF};
    tv[3] = '{5'd3,  32'h0BADF00D, 5'd4,  5'd3,  32'h1,        32'h0BADF00D};
    tv[4] = '{5'd31, 32'h80000000, 5'd31, 5'd31, 32'h80000000, 32'h80000000};
    tv[5] = '{5'd1,  32'h7FFFFFFF, 5'd1,  5'd0,  32'h7FFFFFFF, 32'h0};

    idle_in();
    reset = 1;
    wb_rd = '0; wb_val = '0;
    offer(7'h0, 3'h0, 7'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    decode_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_reset();
    step();  // reset state checked by the model
    idle_in();

    // Table: write a register, issue a read, check operands in the read cycle.
    for (int i = 0; i < 6; i++) begin
      idle_in(); wb(tv[i].wr, tv[i].wval); step();
      idle_in(); offer(7'h33, 3'h0, 7'h0, 32'h0, 5'd2, tv[i].rs1, tv[i].rs2); step();
      idle_in(); exec_done = 1;
      #1;
      chk("tv.read_valid", {31'b0, read_valid}, 32'h1);
      chk("tv.rs1", read_rs1_val, tv[i].e1);
      chk("tv.rs2", read_rs2_val, tv[i].e2);
      step();
    end

    // Writeback then read of x5, x2 = x0.
    idle_in(); wb(5'd5, 32'h12345678); step();
    idle_in(); offer(7'h33, 3'h0, 7'h0, 32'h0, 5'd1, 5'd5, 5'd0);
    #1; chk("t1.ready", {31'b0, decode_ready}, 32'h1);
    step();
    idle_in(); exec_done = 1;
    #1;
    chk("t1.read_valid", {31'b0, read_valid}, 32'h1);
    chk("t1.rs1", read_rs1_val, 32'h12345678);
    chk("t1.rs2", read_rs2_val, 32'h0);
    step();

    // x0 ignores writes.
    idle_in(); wb(5'd0, 32'hFFFFFFFF); step();
    idle_in(); offer(7'h33, 3'h0, 7'h0, 32'h0, 5'd1, 5'd0, 5'd0); step();
    idle_in(); exec_done = 1;
    #1; chk("t2.x0", read_rs1_val, 32'h0);
    step();

    // Writeback in the accept cycle, then a newer one in the read cycle.
    idle_in(); offer(7'h33, 3'h0, 7'h0, 32'h0, 5'd1, 5'd7, 5'd7); wb(5'd7, 32'hA5A5A5A5);
    step();
    idle_in(); wb(5'd7, 32'h5A5A5A5A); exec_done = 1;
    #1;
    chk("t3.rs1", read_rs1_val, 32'h5A5A5A5A);
    chk("t3.rs2", read_rs2_val, 32'h5A5A5A5A);
    step();

    // Multi-cycle shift: processing for three cycles, done on the third.
    idle_in(); offer(7'h13, 3'h1, 7'h00, 32'd20, 5'd9, 5'd5, 5'd0); step();
    idle_in(); offer(7'h33, 3'h7, 7'h20, 32'hFFFF, 5'd3, 5'd1, 5'd1); exec_processing = 1;
    #1;
    chk("t4.rv", {31'b0, read_valid}, 32'h1);
    chk("t4.ready0", {31'b0, decode_ready}, 32'h0);
    step();
    exec_processing = 1;
    #1;
    chk("t4.ready1", {31'b0, decode_ready}, 32'h0);
    chk("t4.rv_low", {31'b0, read_valid}, 32'h0);
    chk("t4.imm", exec_imm, 32'd20);
    chk("t4.opc", {25'b0, exec_opcode}, 32'h13);
    step();
    exec_processing = 1; exec_done = 1;
    #1;
    chk("t4.ready2", {31'b0, decode_ready}, 32'h0);
    chk("t4.illegal", {31'b0, exec_illegal}, 32'h0);
    step();
    idle_in();
    #1;
    chk("t4.ready_after", {31'b0, decode_ready}, 32'h1);
    chk("t4.rd", {27'b0, exec_rd}, 32'd9);
    step();

    // Flush while executing.
    idle_in(); offer(7'h33, 3'h0, 7'h0, 32'h111, 5'd4, 5'd3, 5'd4); step();
    idle_in(); exec_processing = 1; step();
    idle_in(); flush = 1; offer(7'h03, 3'h2, 7'h0, 32'h222, 5'd6, 5'd1, 5'd1);
    #1;
    chk("t5.rv", {31'b0, read_valid}, 32'h0);
    chk("t5.illegal", {31'b0, exec_illegal}, 32'h0);
    chk("t5.ready", {31'b0, decode_ready}, 32'h0);
    step();
    idle_in();
    #1;
    chk("t5.ready_after", {31'b0, decode_ready}, 32'h1);
    chk("t5.imm_kept", exec_imm, 32'h111);
    chk("t5.rv_after", {31'b0, read_valid}, 32'h0);
    step();

    // Flush in the operand cycle suppresses read_valid.
    idle_in(); offer(7'h33, 3'h0, 7'h0, 32'h0, 5'd4, 5'd3, 5'd4); step();
    idle_in(); flush = 1;
    #1; chk("t5b.rv", {31'b0, read_valid}, 32'h0);
    step();

    // Unclaimed opcode.
    idle_in(); offer(7'h7F, 3'h0, 7'h0, 32'h0, 5'd2, 5'd1, 5'd2); step();
    idle_in();
    #1;
    chk("t6.illegal", {31'b0, exec_illegal}, 32'h1);
    chk("t6.rv", {31'b0, read_valid}, 32'h1);
    step();
    #1;
    chk("t6.illegal_off", {31'b0, exec_illegal}, 32'h0);
    chk("t6.ready", {31'b0, decode_ready}, 32'h1);
    chk("t6.opc", {25'b0, exec_opcode}, 32'h7F);
    step();

    // Reset mid-execution clears fields and registers.
    idle_in(); offer(7'h33, 3'h0, 7'h0, 32'h5, 5'd4, 5'd5, 5'd7); step();
    idle_in(); exec_processing = 1; step();
    idle_in(); reset = 1; flush = 1; exec_processing = 1; step();
    idle_in();
    #1;
    chk("rst.ready", {31'b0, decode_ready}, 32'h1);
    chk("rst.opc", {25'b0, exec_opcode}, 32'h0);
    offer(7'h33, 3'h0, 7'h0, 32'h0, 5'd1, 5'd5, 5'd7);
    step();
    idle_in(); exec_done = 1;
    #1; chk("rst.x5", read_rs1_val, 32'h0);
    step();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      reset           = ($urandom_range(0, 199) == 0);
      flush           = ($urandom_range(0, 19) == 0);
      decode_valid    = ($urandom_range(0, 9) < 6);
      decode_opcode   = 7'($urandom);
      decode_funct3   = 3'($urandom);
      decode_funct7   = 7'($urandom);
      decode_imm      = $urandom;
      decode_rd       = 5'($urandom);
      decode_rs1      = 5'($urandom_range(0, 7));
      decode_rs2      = 5'($urandom_range(0, 7));
      wb_valid        = ($urandom_range(0, 1) == 1);
      wb_rd           = 5'($urandom_range(0, 7));
      wb_val          = $urandom;
      exec_processing = ($urandom_range(0, 3) != 0);
      exec_done       = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
